// File: rtl/control_unit.sv
// Purpose : two-cycle instruction decoder and sequencer for the CHARIS 32-bit datapath.
// Latency : each instruction spends one DEC and one COM cycle. Writes commit on the edge that ends COM.
// Backpressure: none. The sequence is RST -> DEC -> COM -> DEC ... with no stall states.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   Instr[31:0], Zero          instruction word (held across DEC+COM), ALU zero flag
//   PC_sel, PC_LdEn            next-PC select, PC write strobe
//   Reset                      datapath reset, high while the FSM is in RST
//   RF_WrEn, RF_WrData_sel     register-file write strobe, write-data select
//   RF_B_sel, ALU_Bin_sel      RF port-B address select, ALU B operand select
//   ALU_func[3:0]              ALU operation code
//   Mem_WrEn                   data-memory write strobe
//   lui, lb, sb                upper-immediate, byte-load and byte-store modes

module control_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Instr,
  input  logic        Zero,
  output logic        PC_sel,
  output logic        PC_LdEn,
  output logic        Reset,
  output logic        RF_WrEn,
  output logic        RF_WrData_sel,
  output logic        RF_B_sel,
  output logic        ALU_Bin_sel,
  output logic [3:0]  ALU_func,
  output logic        Mem_WrEn,
  output logic        lui,
  output logic        lb,
  output logic        sb
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_LUI   = 6'b111001;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SB    = 6'b000111;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;

  // ALU codes used by non-R-type instructions
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  // Decoded controls for the current instruction. The write strobes in here
  // are the per-instruction intent; the FSM only lets them out in COM.
  typedef struct packed {
    logic       pc_sel;
    logic       wr_data_sel;
    logic       b_sel;
    logic       bin_sel;
    logic [3:0] alu_func;
    logic       lui;
    logic       lb;
    logic       sb;
    logic       rf_wr;
    logic       mem_wr;
  } dec_t;

  typedef enum logic [1:0] {
    ST_RST = 2'd0,
    ST_DEC = 2'd1,
    ST_COM = 2'd2
  } state_t;

  state_t     state_q;
  state_t     state_d;
  dec_t       dec;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       func_valid;
  logic       unused_instr;

  assign opcode       = Instr[31:26];
  assign func         = Instr[5:0];
  // Register fields and the immediate are consumed by the datapath, not here.
  assign unused_instr = ^Instr[25:6];

  // R-type funcs live in 11xxxx; low nibbles 0-6, 8-10 and 12-13 are defined.
  always_comb begin
    func_valid = 1'b0;
    if (func[5:4] == 2'b11) begin
      unique case (func[3:0])
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
        4'd8, 4'd9, 4'd10,
        4'd12, 4'd13: func_valid = 1'b1;
        default:      func_valid = 1'b0;
      endcase
    end
  end

  // Instruction decode. Anything not recognised falls through to all-zero
  // controls, which the sequencer turns into a plain PC+4 step.
  always_comb begin
    dec = '0;
    unique case (opcode)
      OP_RTYPE: begin
        if (func_valid) begin
          dec.alu_func = func[3:0];
          dec.rf_wr    = 1'b1;
        end
      end
      OP_LI, OP_ADDI: begin
        dec.alu_func = ALU_ADD;
        dec.bin_sel  = 1'b1;
        dec.rf_wr    = 1'b1;
      end
      OP_LUI: begin
        dec.alu_func = ALU_ADD;
        dec.bin_sel  = 1'b1;
        dec.rf_wr    = 1'b1;
        dec.lui      = 1'b1;
      end
      OP_ANDI: begin
        dec.alu_func = ALU_AND;
        dec.bin_sel  = 1'b1;
        dec.rf_wr    = 1'b1;
      end
      OP_ORI: begin
        dec.alu_func = ALU_OR;
        dec.bin_sel  = 1'b1;
        dec.rf_wr    = 1'b1;
      end
      OP_LB, OP_LW: begin
        dec.alu_func    = ALU_ADD;
        dec.bin_sel     = 1'b1;
        dec.rf_wr       = 1'b1;
        dec.wr_data_sel = 1'b1;
        dec.lb          = (opcode == OP_LB);
      end
      OP_SB, OP_SW: begin
        dec.alu_func = ALU_ADD;
        dec.bin_sel  = 1'b1;
        dec.b_sel    = 1'b1;
        dec.mem_wr   = 1'b1;
        dec.sb       = (opcode == OP_SB);
      end
      OP_B: begin
        dec.alu_func = ALU_ADD;
        dec.pc_sel   = 1'b1;
      end
      // The all-zero word lands here as beq r0,r0,0: taken, but to PC+4.
      OP_BEQ: begin
        dec.alu_func = ALU_SUB;
        dec.b_sel    = 1'b1;
        dec.pc_sel   = Zero;
      end
      OP_BNE: begin
        dec.alu_func = ALU_SUB;
        dec.b_sel    = 1'b1;
        dec.pc_sel   = ~Zero;
      end
      default: dec = '0;
    endcase
  end

  // State register. Asynchronous reset drops the strobes the moment rst_n
  // falls, so a COM in flight never produces a partial commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and outputs.
  always_comb begin
    state_d       = ST_RST;
    Reset         = 1'b0;
    PC_sel        = 1'b0;
    PC_LdEn       = 1'b0;
    RF_WrEn       = 1'b0;
    RF_WrData_sel = 1'b0;
    RF_B_sel      = 1'b0;
    ALU_Bin_sel   = 1'b0;
    ALU_func      = 4'b0000;
    Mem_WrEn      = 1'b0;
    lui           = 1'b0;
    lb            = 1'b0;
    sb            = 1'b0;

    unique case (state_q)
      ST_RST: begin
        state_d = ST_DEC;
        Reset   = 1'b1;
      end
      ST_DEC, ST_COM: begin
        state_d       = (state_q == ST_DEC) ? ST_COM : ST_DEC;
        PC_sel        = dec.pc_sel;
        RF_WrData_sel = dec.wr_data_sel;
        RF_B_sel      = dec.b_sel;
        ALU_Bin_sel   = dec.bin_sel;
        ALU_func      = dec.alu_func;
        lui           = dec.lui;
        lb            = dec.lb;
        sb            = dec.sb;
        if (state_q == ST_COM) begin
          PC_LdEn  = 1'b1;
          RF_WrEn  = dec.rf_wr;
          Mem_WrEn = dec.mem_wr;
        end
      end
      default: begin
        state_d = ST_RST;
        Reset   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Purpose : scoreboard bench for control_unit; expected output vectors are queued when an instruction is driven.
// Latency : two samples per instruction (DEC then COM), taken on the falling edge.
// Backpressure: none; the bench follows the fixed DEC/COM cadence.

module tb_control_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] Instr;
  logic        Zero;
  logic        PC_sel, PC_LdEn, Reset, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel;
  logic [3:0]  ALU_func;
  logic        Mem_WrEn, lui, lb, sb;

  int cmp_cnt = 0;
  int err_cnt = 0;

  logic [14:0] sb_q[$];

  control_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .Instr         (Instr),
    .Zero          (Zero),
    .PC_sel        (PC_sel),
    .PC_LdEn       (PC_LdEn),
    .Reset         (Reset),
    .RF_WrEn       (RF_WrEn),
    .RF_WrData_sel (RF_WrData_sel),
    .RF_B_sel      (RF_B_sel),
    .ALU_Bin_sel   (ALU_Bin_sel),
    .ALU_func      (ALU_func),
    .Mem_WrEn      (Mem_WrEn),
    .lui           (lui),
    .lb            (lb),
    .sb            (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: Reset PC_sel PC_LdEn RF_WrEn WrData_sel B_sel Bin_sel ALU_func Mem_WrEn lui lb sb
  function automatic logic [14:0] ev(input bit rst, input bit pcs, input bit ld, input bit rfw,
                                     input bit wds, input bit bs, input bit bin, input logic [3:0] f,
                                     input bit mw, input bit lu, input bit lbb, input bit sbb);
    return {rst, pcs, ld, rfw, wds, bs, bin, f, mw, lu, lbb, sbb};
  endfunction

  function automatic logic [14:0] outs();
    return {Reset, PC_sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel,
            ALU_func, Mem_WrEn, lui, lb, sb};
  endfunction

  // One instruction case: selects, plus the strobes expected in COM.
  typedef struct {
    string       name;
    logic [31:0] instr;
    bit          zero;
    bit          pcs, wds, bs, bin;
    logic [3:0]  f;
    bit          lu, lbb, sbb;
    bit          rfw, mw;
  } case_t;

  // Drive one instruction at the start of DEC and queue its two expectations.
  task automatic issue(input case_t c);
    Instr = c.instr;
    Zero  = c.zero;
    sb_q.push_back(ev(0, c.pcs, 0, 0, c.wds, c.bs, c.bin, c.f, 0, c.lu, c.lbb, c.sbb));
    sb_q.push_back(ev(0, c.pcs, 1, c.rfw, c.wds, c.bs, c.bin, c.f, c.mw, c.lu, c.lbb, c.sbb));
  endtask

  task automatic run_cases(input string tag, input case_t tbl[$]);
    logic [14:0] got, exp;
    foreach (tbl[i]) begin
      issue(tbl[i]);
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        got = outs();
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 15'h7fff;
        cmp_cnt++;
        if (got !== exp) begin
          err_cnt++;
          $display("FAIL %s/%s %s: got %b expected %b", tag, tbl[i].name, (k == 0) ? "dec" : "com", got, exp);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    logic [14:0] got, exp;
    rst_n = 1'b0;
    Instr = 32'h0;
    Zero  = 1'b0;
    #12;
    sb_q.push_back(ev(1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
    sb_q.push_back(ev(1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
    got = outs();
    exp = sb_q.pop_front();
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL reset_asserted: got %b expected %b", got, exp);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    got = outs();
    exp = sb_q.pop_front();
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL reset_after_release: got %b expected %b", got, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_nop();
    case_t t[$];
    t.push_back('{"nop",      32'h00000000, 0, 0, 0, 1, 0, 4'b0001, 0, 0, 0, 0, 0});
    t.push_back('{"nop_zero", 32'h00000000, 1, 1, 0, 1, 0, 4'b0001, 0, 0, 0, 0, 0});
    run_cases("nop", t);
  endtask

  task automatic test_imm();
    case_t t[$];
    t.push_back('{"li",   32'hE0010002, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 1, 0});
    t.push_back('{"lui",  32'hE4031234, 0, 0, 0, 0, 1, 4'b0000, 1, 0, 0, 1, 0});
    t.push_back('{"addi", 32'hC0410005, 1, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 1, 0});
    t.push_back('{"andi", 32'hC8410005, 0, 0, 0, 0, 1, 4'b0010, 0, 0, 0, 1, 0});
    t.push_back('{"ori",  32'hCC410005, 0, 0, 0, 0, 1, 4'b0011, 0, 0, 0, 1, 0});
    run_cases("imm", t);
  endtask

  task automatic test_rtype();
    case_t t[$];
    t.push_back('{"add",     32'h80461030, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 1, 0});
    t.push_back('{"sub",     32'h80461031, 1, 0, 0, 0, 0, 4'b0001, 0, 0, 0, 1, 0});
    t.push_back('{"nor",     32'h80461036, 0, 0, 0, 0, 0, 4'b0110, 0, 0, 0, 1, 0});
    t.push_back('{"sra",     32'h80461038, 0, 0, 0, 0, 0, 4'b1000, 0, 0, 0, 1, 0});
    t.push_back('{"sll",     32'h8046103A, 0, 0, 0, 0, 0, 4'b1010, 0, 0, 0, 1, 0});
    t.push_back('{"rol",     32'h8046103C, 0, 0, 0, 0, 0, 4'b1100, 0, 0, 0, 1, 0});
    t.push_back('{"ror",     32'h8046103D, 0, 0, 0, 0, 0, 4'b1101, 0, 0, 0, 1, 0});
    t.push_back('{"bad_37",  32'h80461037, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0});
    t.push_back('{"bad_3b",  32'h8046103B, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0});
    t.push_back('{"bad_3e",  32'h8046103E, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0});
    t.push_back('{"bad_00",  32'h80461000, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0});
    run_cases("rtype", t);
  endtask

  task automatic test_mem();
    case_t t[$];
    t.push_back('{"sb", 32'h1C000004, 0, 0, 0, 1, 1, 4'b0000, 0, 0, 1, 0, 1});
    t.push_back('{"sw", 32'h7C220004, 0, 0, 0, 1, 1, 4'b0000, 0, 0, 0, 0, 1});
    t.push_back('{"lb", 32'h0C220008, 0, 0, 1, 0, 1, 4'b0000, 0, 1, 0, 1, 0});
    t.push_back('{"lw", 32'h3C220008, 0, 0, 1, 0, 1, 4'b0000, 0, 0, 0, 1, 0});
    run_cases("mem", t);
  endtask

  task automatic test_branch();
    case_t t[$];
    t.push_back('{"beq_z0", 32'h01C20003, 0, 0, 0, 1, 0, 4'b0001, 0, 0, 0, 0, 0});
    t.push_back('{"beq_z1", 32'h01C20003, 1, 1, 0, 1, 0, 4'b0001, 0, 0, 0, 0, 0});
    t.push_back('{"bne_z0", 32'h05C20003, 0, 1, 0, 1, 0, 4'b0001, 0, 0, 0, 0, 0});
    t.push_back('{"bne_z1", 32'h05C20003, 1, 0, 0, 1, 0, 4'b0001, 0, 0, 0, 0, 0});
    t.push_back('{"b",      32'hFC000010, 0, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0});
    run_cases("branch", t);
  endtask

  task automatic test_undefined();
    case_t t[$];
    t.push_back('{"op02", 32'h08FFFFFF, 1, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0});
    t.push_back('{"op2a", 32'hA8000000, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0});
    t.push_back('{"op31", 32'hC4410005, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0});
    run_cases("undef", t);
  endtask

  // Random mix drawn from a few known encodings, back to back.
  task automatic test_back_to_back();
    case_t pool[$];
    case_t t[$];
    pool.push_back('{"li",  32'hE0010002, 0, 0, 0, 0, 1, 4'b0000, 0, 0, 0, 1, 0});
    pool.push_back('{"sw",  32'h7C220004, 0, 0, 0, 1, 1, 4'b0000, 0, 0, 0, 0, 1});
    pool.push_back('{"bne", 32'h05C20003, 0, 1, 0, 1, 0, 4'b0001, 0, 0, 0, 0, 0});
    pool.push_back('{"or",  32'h80461033, 0, 0, 0, 0, 0, 4'b0011, 0, 0, 0, 1, 0});
    for (int i = 0; i < 12; i++) t.push_back(pool[$urandom_range(0, 3)]);
    run_cases("b2b", t);
  endtask

  // Reset pulsed in the middle of a store's COM cycle.
  task automatic test_reset_mid();
    logic [14:0] got, exp;
    Instr = 32'h7C220004;
    Zero  = 1'b0;
    sb_q.push_back(ev(0, 0, 1, 0, 0, 1, 1, 4'b0000, 1, 0, 0, 0));
    sb_q.push_back(ev(1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
    @(posedge clk); #1;                      // now in COM
    @(negedge clk);
    got = outs();
    exp = sb_q.pop_front();
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL rst_mid/com_before: got %b expected %b", got, exp);
    end
    #1 rst_n = 1'b0;
    #1;
    got = outs();
    exp = sb_q.pop_front();
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL rst_mid/after_assert: got %b expected %b", got, exp);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;                      // back in DEC
  endtask

  initial begin
    test_reset();
    test_nop();
    test_imm();
    test_rtype();
    test_mem();
    test_branch();
    test_undefined();
    test_back_to_back();
    test_reset_mid();
    test_nop();
    if (sb_q.size() != 0) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction-decode and sequencing controller for the CHARIS-style 32-bit processor datapath. It decodes the current instruction word and the ALU Zero flag into datapath mux selects, ALU function, byte-mode flags and write strobes. A small state machine gives each instruction two clock cycles. Writes (PC, register file, memory) are only enabled in the second cycle, so every decoded select is stable before it is committed.

## Interface
- No parameters.
- clk  in  1  system clock, rising-edge active
- rst_n  in  1  asynchronous active-low reset
- Instr  in  32  current instruction; opcode Instr[31:26], rs Instr[25:21], rd Instr[20:16], rt Instr[15:11], func Instr[5:0]
- Zero  in  1  ALU result == 0
- PC_sel  out  1  0 = PC+4, 1 = PC+4+(SignExt(Instr[15:0])<<2)
- PC_LdEn  out  1  PC write enable
- Reset  out  1  datapath reset, active-high
- RF_WrEn  out  1  register-file write enable (dest = rd)
- RF_WrData_sel  out  1  0 = ALU result, 1 = memory data
- RF_B_sel  out  1  RF read port B address: 0 = rt, 1 = rd
- ALU_Bin_sel  out  1  ALU B operand: 0 = RF port B, 1 = immediate
- ALU_func  out  4  ALU operation
- Mem_WrEn  out  1  data-memory write enable
- lui  out  1  immediate = Instr[15:0]<<16
- lb  out  1  byte load (zero-extend low byte)
- sb  out  1  byte store (low byte)

## Operation
- ALU_func codes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 not, 0101 nand, 0110 nor, 1000 sra, 1001 srl, 1010 sll, 1100 rol, 1101 ror.
- R-type (opcode 100000):
  - Valid func values are 110000–110110 and 111000–111010, 111100–111101.
  - ALU_func = func[3:0], RF_WrEn=1, ALU_Bin_sel=0, RF_B_sel=0, RF_WrData_sel=0.
- Immediate ALU instructions, all with RF_WrEn=1, ALU_Bin_sel=1:
  - li 111000: ALU_func 0000
  - lui 111001: ALU_func 0000, lui=1
  - addi 110000: ALU_func 0000
  - andi 110010: ALU_func 0010
  - ori 110011: ALU_func 0011
- Loads: lb 000011 and lw 001111.
  - ALU_func 0000, ALU_Bin_sel=1, RF_WrEn=1, RF_WrData_sel=1.
  - lb=1 for lb only.
- Stores: sb 000111 and sw 011111.
  - ALU_func 0000, ALU_Bin_sel=1, RF_B_sel=1, Mem_WrEn=1.
  - sb=1 for sb only.
- Branches:
  - b 111111: PC_sel=1 unconditionally; ALU_func 0000.
  - beq 000000: ALU_func 0001, RF_B_sel=1, ALU_Bin_sel=0; PC_sel = Zero.
  - bne 000001: same selects as beq; PC_sel = ~Zero.
- All-zero word = beq r0,r0,0 and behaves as nop: branch taken to PC+4, no RF/memory write.
- Undefined opcode or R-type func: treated as nop.
  - RF_WrEn, Mem_WrEn, PC_sel, lui, lb, sb all 0; ALU_func 0000.
  - PC_LdEn still pulses, so the PC advances by 4.
- Unlisted select outputs are 0 for every instruction.

## Timing
- States: RST, DEC, COM.
- rst_n low:
  - Asynchronous entry to RST.
  - Reset=1; every other output 0.
- Sequencing:
  - The first rising edge after rst_n rises moves RST to DEC.
  - Reset stays 1 throughout RST.
  - After that the sequence is DEC → COM → DEC … with no stall states.
- DEC: decoded selects (PC_sel, RF_WrData_sel, RF_B_sel, ALU_Bin_sel, ALU_func, lui, lb, sb) are driven combinationally from Instr/Zero. All strobes (PC_LdEn, RF_WrEn, Mem_WrEn) are 0.
- COM:
  - Same selects as in DEC.
  - PC_LdEn=1.
  - RF_WrEn and Mem_WrEn are per instruction.
  - The datapath commits on the rising edge that ends COM.
- Instr and Zero must be held stable across DEC+COM. The instruction latency is exactly 2 cycles.
- Zero is evaluated combinationally in COM for PC_sel.
- Reset asserted mid-instruction: the commit is abandoned and strobes drop immediately, with no partial write.

## Test plan
- Reset, then nop (Instr=0x00000000, Zero=0):
  - Reset=1 while rst_n=0 and for one cycle after release.
  - Then DEC: all strobes 0.
  - COM: PC_LdEn=1, RF_WrEn=0, Mem_WrEn=0, PC_sel=0.
- li $1,2 (0xE0010002):
  - ALU_Bin_sel=1, ALU_func=0000, RF_WrData_sel=0.
  - RF_WrEn=1 only in COM.
- add $6,$2,$2 (0x80461030): ALU_func=0000, ALU_Bin_sel=0, RF_B_sel=0, RF_WrEn=1 in COM.
- beq $14,$2,3 (0x01C20003):
  - RF_B_sel=1, ALU_func=0001, RF_WrEn=0.
  - Zero=0 → PC_sel=0; Zero=1 → PC_sel=1.
  - bne with the same operands gives the inverse.
- sb (0x1C000004): Mem_WrEn=1 and sb=1 in COM, RF_WrEn=0.
  - lb gives lb=1, RF_WrData_sel=1.
  - lui gives lui=1.
- rst_n pulsed low during COM of sw: Mem_WrEn and PC_LdEn drop to 0 immediately and Reset=1.
